config_streamer: RTL and testbench
==================================

CONFIG_STREAMER -- requirements
Module: config_streamer

Interface
REQ-001 SHALL have parameter END_MARKER, default 32'hFFFFFFFF: an address word equal to this value terminates the stream.
REQ-002 SHALL have parameter GAP_CYCLES, default 1, legal range 0..15: idle cycles inserted after each config write.
REQ-003 SHALL have port clk_in, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin streaming.
REQ-006 SHALL have port s_valid, input, 1: the source word on s_data is valid.
REQ-007 SHALL have port s_data, input, 32: bitstream word, address and data words alternating.
REQ-008 SHALL have port s_ready, output, 1: the block accepts s_data this cycle.
REQ-009 SHALL have port config_addr, output, 32: config address driven to the tile.
REQ-010 SHALL have port config_data, output, 32: config data driven to the tile.
REQ-011 SHALL have port config_en, output, 1: one-cycle config write strobe.
REQ-012 SHALL have port busy, output, 1: high while a stream is in progress.
REQ-013 SHALL have port done, output, 1: sticky end-of-stream flag.
REQ-014 SHALL have port write_count, output, 16: number of writes issued in the current or last stream.

Function
REQ-015 SHALL implement the states IDLE, GET_ADDR, GET_DATA, WRITE, GAP and DONE.
REQ-016 SHALL register all outputs, except that s_ready SHALL be decoded from the state register only and SHALL NOT depend on s_valid.
REQ-017 SHALL accept a word only on the handshake s_valid && s_ready.
REQ-018 IDLE: s_ready=0, busy=0; start=1 moves to GET_ADDR, clears write_count to 0 and clears done.
REQ-019 GET_ADDR: s_ready=1, busy=1.
- On a handshake with s_data==END_MARKER: move to DONE.
- On a handshake with any other value: latch the value as the pending address and move to GET_DATA.
REQ-020 GET_DATA: s_ready=1, busy=1; on a handshake, latch the pending data and move to WRITE.
REQ-021 WRITE: for exactly one cycle, config_en=1 with config_addr and config_data showing the pending pair; write_count increments by 1, saturating at 16'hFFFF.
- From WRITE: go to GAP if GAP_CYCLES>0, else to GET_ADDR.
REQ-022 GAP: s_ready=0, busy=1; stay exactly GAP_CYCLES cycles, then go to GET_ADDR.
REQ-023 Latency: a data-word handshake in cycle N SHALL give config_en=1 in cycle N+1.
REQ-024 config_addr and config_data SHALL hold their last written values between writes and after DONE.
REQ-025 DONE: done=1, busy=0, s_ready=0; start=1 behaves as in IDLE, including the clear of done in the next cycle.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 Source stalls (s_valid=0) in GET_ADDR or GET_DATA SHALL hold the state indefinitely, with no timeout.
REQ-028 An END_MARKER value arriving in GET_DATA SHALL be treated as ordinary data and written.

Reset
REQ-029 reset=0 SHALL, asynchronously, force the state to IDLE and drive these values: config_addr=0, config_data=0, config_en=0, s_ready=0, busy=0, done=0, write_count=0.
REQ-030 Reset asserted mid-stream SHALL abort any pending write, so that no config_en pulse follows the reset.
REQ-031 After reset release, the block SHALL stay in IDLE until start=1.

Verification
REQ-032 Basic write, GAP_CYCLES=1: start, then words 32'h00080015 and 32'h000001EA with s_valid continuous.
- Required: one config_en pulse, with config_addr=32'h00080015 and config_data=32'h000001EA, one cycle after the data handshake.
- Required: s_ready=0 for 1 cycle after the pulse.
REQ-033 Termination: three address/data pairs, then 32'hFFFFFFFF.
- Required: three config_en pulses, done=1, busy=0, write_count=3.
- Required: config_addr and config_data equal the third pair.
REQ-034 Stalls: s_valid toggled 0/1 every cycle over two pairs.
- Required: exactly two config_en pulses with the correct pairs.
- Required: no word is accepted while s_valid=0.
REQ-035 Mid-stream reset: reset=0 for one cycle after an address handshake and before the data word.
- Required: all outputs go to their reset values immediately and no config_en pulse occurs.
- Required: a fresh start then works normally.
REQ-036 GAP_CYCLES=0, back-to-back pairs: config_en pulses spaced exactly 3 cycles apart (WRITE, GET_ADDR, GET_DATA).
REQ-037 Restart and start-while-busy: start pulsed while busy has no effect; start pulsed in DONE clears done and write_count, and a new stream of 1 pair gives write_count=1.

Source files
------------

// File: rtl/config_streamer.sv
// Streams address/data word pairs from a valid/ready source into
// single-cycle config writes, stopping at END_MARKER.
// Ports: clk_in, reset (async active-low), start; s_valid, s_data and
//   s_ready form the source handshake; config_addr, config_data and
//   config_en carry the write; busy, done and write_count report status.
module config_streamer #(
  parameter logic [31:0] END_MARKER = 32'hFFFFFFFF,
  parameter int          GAP_CYCLES = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] write_count
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    GAP,
    DONE
  } state_t;

  // gap_cnt counts down to zero, so it starts at GAP_CYCLES-1
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t      state;
  logic [31:0] pend_addr;
  logic [3:0]  gap_cnt;
  logic        hs;

  // Decoded from state alone so s_ready never depends on s_valid
  assign s_ready = (state == GET_ADDR) || (state == GET_DATA);
  assign hs      = s_valid && s_ready;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pend_addr   <= '0;
      gap_cnt     <= '0;
      config_addr <= '0;
      config_data <= '0;
      config_en   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      write_count <= '0;
    end else begin
      config_en <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= GET_ADDR;
            busy        <= 1'b1;
            done        <= 1'b0;
            write_count <= '0;
          end
        end
        GET_ADDR: begin
          if (hs) begin
            if (s_data == END_MARKER) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pend_addr <= s_data;
              state     <= GET_DATA;
            end
          end
        end
        GET_DATA: begin
          // Outputs load here so the strobe shows during WRITE
          if (hs) begin
            config_addr <= pend_addr;
            config_data <= s_data;
            config_en   <= 1'b1;
            if (write_count != 16'hFFFF)
              write_count <= write_count + 16'd1;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (GAP_CYCLES > 0) begin
            gap_cnt <= 4'(GAP_LOAD);
            state   <= GAP;
          end else begin
            state <= GET_ADDR;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0)
            state <= GET_ADDR;
          else
            gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_streamer.sv
// Scoreboard bench for config_streamer: random word streams feed a
// pair-level model; a monitor checks every config write it sees.
module tb_config_streamer;

  localparam int          GAP  = 1;
  localparam logic [31:0] ENDM = 32'hFFFFFFFF;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start, s_valid, s_ready;
  logic [31:0] s_data, config_addr, config_data;
  logic        config_en, busy, done;
  logic [15:0] write_count;

  logic        g_start, g_valid, g_ready;
  logic [31:0] g_data, g_addr, g_cdata;
  logic        g_en, g_busy, g_done;
  logic [15:0] g_count;

  always #5 clk_in = ~clk_in;

  config_streamer #(.END_MARKER(ENDM), .GAP_CYCLES(GAP)) u_dut (
    .clk_in(clk_in), .reset(reset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .busy(busy), .done(done),
    .write_count(write_count)
  );

  config_streamer #(.END_MARKER(ENDM), .GAP_CYCLES(0)) u_gap0 (
    .clk_in(clk_in), .reset(reset), .start(g_start),
    .s_valid(g_valid), .s_data(g_data), .s_ready(g_ready),
    .config_addr(g_addr), .config_data(g_cdata),
    .config_en(g_en), .busy(g_busy), .done(g_done),
    .write_count(g_count)
  );

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  bit          m_have_addr;
  logic [31:0] m_addr;
  int          m_count;
  logic [31:0] m_last_a, m_last_d;
  int          en_cyc = -100;
  bit          tog;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Pair-level model: words alternate address/data; END only ends
  // the stream in address position. Write shows the cycle after.
  function automatic void model_accept(input logic [31:0] w,
                                       input int c);
    if (!m_have_addr) begin
      if (w != ENDM) begin
        m_have_addr = 1'b1;
        m_addr      = w;
      end
    end else begin
      exp_q.push_back('{m_addr, w, c + 1});
      m_have_addr = 1'b0;
      if (m_count < 65535) m_count++;
      m_last_a = m_addr;
      m_last_d = w;
    end
  endfunction

  always @(negedge clk_in) begin
    if (reset === 1'b1) begin
      if (config_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: actual addr=%h data=%h required none",
                   config_addr, config_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", config_addr, mon_e.a);
          chk("write_data", config_data, mon_e.d);
          chk("write_cycle", 32'(cyc), 32'(mon_e.c));
          chk("write_ready", 32'(s_ready), 32'd0);
        end
        en_cyc = cyc;
      end else if (exp_q.size() > 0 && cyc > exp_q[0].c) begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_write: actual none required addr=%h data=%h",
                 mon_e.a, mon_e.d);
      end
      if (cyc > en_cyc && cyc <= en_cyc + GAP)
        chk("gap_ready", 32'(s_ready), 32'd0);
      if (cyc == en_cyc + GAP + 1)
        chk("after_gap_ready", 32'(s_ready), 32'd1);
    end
  end

  task automatic do_start();
    @(negedge clk_in);
    start       = 1'b1;
    m_count     = 0;
    m_have_addr = 1'b0;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  // mode 0: continuous valid, 1: toggling, 2: random stalls
  task automatic send_word(input logic [31:0] w, input int mode);
    bit v;
    bit sent;
    sent = 1'b0;
    for (int t = 0; t < 200 && !sent; t++) begin
      @(negedge clk_in);
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      tog     = ~tog;
      s_valid = v;
      s_data  = v ? w : $urandom();
      if (v && s_ready) begin
        model_accept(w, cyc);
        sent = 1'b1;
      end
    end
    if (!sent) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: actual no s_ready required accept of %h", w);
    end
  endtask

  task automatic finish_stream(input int mode, input string nm);
    send_word(ENDM, mode);
    @(negedge clk_in);
    s_valid = 1'b0;
    @(negedge clk_in);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_ready"}, 32'(s_ready), 32'd0);
    chk({nm, "_count"}, 32'(write_count), 32'(m_count));
    chk({nm, "_hold_addr"}, config_addr, m_last_a);
    chk({nm, "_hold_data"}, config_data, m_last_d);
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_addr"}, config_addr, 32'd0);
    chk({nm, "_data"}, config_data, 32'd0);
    chk({nm, "_en"}, 32'(config_en), 32'd0);
    chk({nm, "_ready"}, 32'(s_ready), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_count"}, 32'(write_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [31:0] gw[7];
    int          en_list[$];
    int          idx;
    int          np, md;

    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    g_start = 1'b0;
    g_valid = 1'b0;
    g_data  = '0;
    tog     = 1'b0;
    m_last_a = '0;
    m_last_d = '0;
    m_count  = 0;

    repeat (2) @(negedge clk_in);
    chk_reset_vals("por");
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(s_ready), 32'd0);

    // basic write then termination after three pairs
    do_start();
    send_word(32'h00080015, 0);
    send_word(32'h000001EA, 0);
    for (int p = 0; p < 2; p++) begin
      a = $urandom();
      if (a == ENDM) a = 32'h0;
      send_word(a, 0);
      send_word($urandom(), 0);
    end
    finish_stream(0, "term");

    // toggling valid, with a start pulse while busy
    do_start();
    send_word(32'h11112222, 1);
    @(negedge clk_in);
    s_valid = 1'b0;
    start   = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    send_word(32'h33334444, 1);
    send_word(32'h55556666, 1);
    send_word(32'h77778888, 1);
    finish_stream(1, "stall");

    // random streams; one carries END_MARKER as data
    for (int s = 0; s < 4; s++) begin
      np = $urandom_range(1, 4);
      md = $urandom_range(0, 2);
      do_start();
      for (int p = 0; p < np; p++) begin
        a = $urandom();
        if (a == ENDM) a = 32'h1;
        d = (s == 1 && p == 0) ? ENDM : $urandom();
        send_word(a, md);
        send_word(d, md);
      end
      finish_stream(md, "rand");
    end

    // restart from DONE clears done and count
    do_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_count", 32'(write_count), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    send_word(32'h0000ABCD, 0);
    send_word(32'h12345678, 0);
    finish_stream(0, "restart");

    // reset between address and data words
    do_start();
    send_word(32'hDEAD0001, 0);
    @(negedge clk_in);
    s_valid = 1'b0;
    reset   = 1'b0;
    #1;
    chk_reset_vals("midrst");
    m_have_addr = 1'b0;
    m_count     = 0;
    m_last_a    = '0;
    m_last_d    = '0;
    @(negedge clk_in);
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hBEEF0002;
    repeat (3) @(negedge clk_in);
    chk("midrst_idle_busy", 32'(busy), 32'd0);
    chk("midrst_idle_en", 32'(config_en), 32'd0);
    s_valid = 1'b0;
    do_start();
    send_word(32'h00000042, 0);
    send_word(32'hCAFEF00D, 0);
    finish_stream(0, "fresh");

    // zero-gap instance: back-to-back pairs three cycles apart
    gw = '{32'hA0, 32'hD0, 32'hA1, 32'hD1, 32'hA2, 32'hD2, ENDM};
    @(negedge clk_in);
    g_start = 1'b1;
    @(negedge clk_in);
    g_start = 1'b0;
    idx = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk_in);
      if (g_en) begin
        if (en_list.size() < 3) begin
          chk("gap0_addr", g_addr, gw[2 * en_list.size()]);
          chk("gap0_data", g_cdata, gw[2 * en_list.size() + 1]);
        end
        en_list.push_back(cyc);
      end
      if (idx < 7) begin
        g_valid = 1'b1;
        g_data  = gw[idx];
        if (g_ready) idx++;
      end else begin
        g_valid = 1'b0;
      end
    end
    chk("gap0_pulses", 32'(en_list.size()), 32'd3);
    for (int i = 1; i < en_list.size(); i++)
      chk("gap0_spacing", 32'(en_list[i] - en_list[i-1]), 32'd3);
    chk("gap0_done", 32'(g_done), 32'd1);
    chk("gap0_count", 32'(g_count), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
